mem_ctrl: RTL and testbench

Memory controller and arbiter sharing the CPU's single byte-wide RAM/IO port between the instruction-fetch stage and the MEM stage.
- Serializes 1/2/4-byte requests into byte transactions and assembles little-endian words from returned bytes.
- Drives the top-level memory bus (address, data out, write strobe) and honours the global `rdy_in` pause.
- Sits between IF/MEM and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

---
 rtl/mem_ctrl_if.sv | 34 +++
 rtl/mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the CPU stages (IF/MEM), the memory controller and the byte-wide RAM port.
// Signal names keep the controller-side direction suffixes.
interface mem_ctrl_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic        busy_o;

  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, ram_din_i,
    output if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o,
           ram_wr_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_addr_i,
           mem_wdata_i, ram_din_i,
    input  if_data_o, if_done_o, mem_rdata_o, mem_done_o, ram_dout_o, ram_a_o,
           ram_wr_o, busy_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter for IF and MEM: serialises 1/2/4-byte accesses and
// assembles little-endian words; MEM has fixed priority over IF.
module mem_ctrl (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  state_e      state_q;
  logic        port_mem_q;
  logic [31:0] base_q;
  logic [2:0]  n_q;
  logic [2:0]  iss_q;
  logic [2:0]  rcv_q;
  logic        prime_q;
  logic [31:0] buf_q;
  logic [31:0] wdata_q;
  logic [31:0] ram_a_q;
  logic [7:0]  ram_dout_q;
  logic        wr_q;
  logic [31:0] if_data_q;
  logic [31:0] mem_rdata_q;
  logic        if_done_q;
  logic        mem_done_q;
  logic        busy_q;

  logic        grant_mem;
  logic        grant_if;
  logic [31:0] grant_addr;
  logic [2:0]  grant_n;
  logic [2:0]  iss_nx;
  logic [2:0]  rcv_nx;
  logic        capture;
  logic [31:0] buf_d;
  logic [31:0] next_a;
  logic [7:0]  next_wb;

  always_comb begin
    grant_mem  = bus.mem_req_i && !if_done_q && !mem_done_q;
    grant_if   = bus.if_req_i && !bus.mem_req_i && !if_done_q && !mem_done_q;
    grant_addr = grant_mem ? bus.mem_addr_i : bus.if_addr_i;
    if (!grant_mem)             grant_n = 3'd4;
    else if (bus.mem_len_i[1])  grant_n = 3'd4;
    else if (bus.mem_len_i[0])  grant_n = 3'd2;
    else                        grant_n = 3'd1;
    iss_nx  = iss_q + 3'd1;
    rcv_nx  = rcv_q + 3'd1;
    // iss counts addresses whose bus cycle has completed, so the byte on
    // ram_din_i belongs to index rcv whenever rcv < iss.
    capture = !prime_q && (rcv_q < iss_q);
    buf_d   = buf_q;
    if (capture) buf_d[{rcv_q[1:0], 3'b000} +: 8] = bus.ram_din_i;
    next_a  = base_q + {29'd0, iss_nx};
    next_wb = wdata_q[{iss_nx[1:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      port_mem_q  <= 1'b0;
      base_q      <= '0;
      n_q         <= '0;
      iss_q       <= '0;
      rcv_q       <= '0;
      prime_q     <= 1'b0;
      buf_q       <= '0;
      wdata_q     <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      wr_q        <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (!rdy_in) begin
        // A stalled read drops in-flight bytes; the address register is
        // rewound now so the prime cycle re-drives base + rcv.
        if (state_q == READ) begin
          iss_q   <= rcv_q;
          prime_q <= 1'b1;
          ram_a_q <= base_q + {29'd0, rcv_q};
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            if (grant_mem || grant_if) begin
              port_mem_q <= grant_mem;
              base_q     <= grant_addr;
              n_q        <= grant_n;
              wdata_q    <= bus.mem_wdata_i;
              iss_q      <= '0;
              rcv_q      <= '0;
              prime_q    <= 1'b0;
              buf_q      <= '0;
              ram_a_q    <= grant_addr;
              busy_q     <= 1'b1;
              if (grant_mem && bus.mem_we_i) begin
                state_q    <= WRITE;
                wr_q       <= 1'b1;
                ram_dout_q <= bus.mem_wdata_i[7:0];
              end else begin
                state_q <= READ;
              end
            end
          end
          READ: begin
            prime_q <= 1'b0;
            if (iss_q < n_q) begin
              iss_q <= iss_nx;
              if (iss_nx < n_q) ram_a_q <= next_a;
            end
            if (capture) begin
              buf_q <= buf_d;
              rcv_q <= rcv_nx;
              if (rcv_nx == n_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (port_mem_q) begin
                  mem_rdata_q <= buf_d;
                  mem_done_q  <= 1'b1;
                end else begin
                  if_data_q <= buf_d;
                  if_done_q <= 1'b1;
                end
              end
            end
          end
          WRITE: begin
            if (iss_nx < n_q) begin
              iss_q      <= iss_nx;
              ram_a_q    <= next_a;
              ram_dout_q <= next_wb;
            end else begin
              wr_q       <= 1'b0;
              mem_done_q <= 1'b1;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.if_data_o   = if_data_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.ram_dout_o  = ram_dout_q;
  assign bus.ram_a_o     = ram_a_q;
  assign bus.ram_wr_o    = wr_q & rdy_in;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model plus a scoreboard of expected
// IF/MEM completions, with cycle-accurate bus and timing checks.
module tb_mem_ctrl;

  typedef struct {
    bit          rd;
    logic [31:0] data;
  } mexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0]  ram  [0:1023];
  int          wcnt [0:1023];
  logic [31:0] if_q[$];
  mexp_t       mem_q[$];
  mexp_t       mon_e;
  logic [31:0] last_mem_rd = '0;

  mem_ctrl_if bus();

  mem_ctrl u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: data for the address driven in cycle k appears in cycle k+1.
  always @(posedge clk) begin
    if (bus.ram_wr_o) begin
      ram[bus.ram_a_o[9:0]]  <= bus.ram_dout_o;
      wcnt[bus.ram_a_o[9:0]] <= wcnt[bus.ram_a_o[9:0]] + 1;
    end
    bus.ram_din_i <= ram[bus.ram_a_o[9:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_done_o) begin
      if (if_q.size() == 0) check_val("if_unexpected_done", bus.if_done_o, 0);
      else check_val("if_data", bus.if_data_o, if_q.pop_front());
    end
    if (bus.mem_done_o) begin
      if (mem_q.size() == 0) check_val("mem_unexpected_done", bus.mem_done_o, 0);
      else begin
        mon_e = mem_q.pop_front();
        if (mon_e.rd) last_mem_rd = mon_e.data;
        check_val(mon_e.rd ? "mem_rdata" : "mem_rdata_held", bus.mem_rdata_o, last_mem_rd);
      end
    end
  end

  task automatic start_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input bit is_mem, input logic [1:0] len, input logic [31:0] addr,
                          input logic [31:0] exp, input int exp_done);
    int n;
    bit got;
    n = (!is_mem || len[1]) ? 4 : (len[0] ? 2 : 1);
    got = 1'b0;
    start_cycle();
    if (is_mem) begin
      bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = len; bus.mem_addr_i = addr;
      mem_q.push_back('{1'b1, exp});
    end else begin
      bus.if_req_i = 1'b1; bus.if_addr_i = addr;
      if_q.push_back(exp);
    end
    for (int k = 1; k <= 30 && !got; k++) begin
      start_cycle();
      @(negedge clk);
      if (k <= n) check_val("rd_addr", bus.ram_a_o, addr + k - 1);
      if (bus.mem_done_o || bus.if_done_o) begin
        got = 1'b1;
        check_val("rd_done_cycle", k, exp_done);
        bus.mem_req_i = 1'b0;
        bus.if_req_i  = 1'b0;
      end
    end
    check_val("rd_timeout", got, 1);
  endtask

  task automatic run_write(input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_done);
    int n;
    bit got;
    logic [31:0] sh;
    n = len[1] ? 4 : (len[0] ? 2 : 1);
    got = 1'b0;
    start_cycle();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = len;
    bus.mem_addr_i = addr; bus.mem_wdata_i = wdata;
    mem_q.push_back('{1'b0, 32'h0});
    for (int k = 1; k <= 30 && !got; k++) begin
      start_cycle();
      @(negedge clk);
      if (k <= n) begin
        sh = wdata >> (8 * (k - 1));
        check_val("wr_strobe", bus.ram_wr_o, 1);
        check_val("wr_addr", bus.ram_a_o, addr + k - 1);
        check_val("wr_byte", bus.ram_dout_o, sh & 32'hFF);
      end
      if (bus.mem_done_o) begin
        got = 1'b1;
        check_val("wr_done_cycle", k, exp_done);
        bus.mem_req_i = 1'b0;
      end
    end
    check_val("wr_timeout", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int ones;
    for (int i = 0; i < 1024; i++) begin
      ram[i]  = 8'h00;
      wcnt[i] = 0;
    end
    {ram[16'h103], ram[16'h102], ram[16'h101], ram[16'h100]} = 32'h00A00513;
    {ram[16'h203], ram[16'h202], ram[16'h201], ram[16'h200]} = 32'h00100093;
    ram[16'h204] = 8'hFF;
    {ram[16'h33], ram[16'h32], ram[16'h31], ram[16'h30]} = 32'hAAAAAAAA;
    {ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]} = 32'h44332211;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_len_i = '0;
    bus.mem_addr_i = '0; bus.mem_wdata_i = '0;

    // Reset state
    repeat (3) start_cycle();
    @(negedge clk);
    check_val("rst_if_data", bus.if_data_o, 0);
    check_val("rst_mem_rdata", bus.mem_rdata_o, 0);
    check_val("rst_ram_a", bus.ram_a_o, 0);
    check_val("rst_ram_wr", bus.ram_wr_o, 0);
    check_val("rst_busy", bus.busy_o, 0);
    check_val("rst_dones", {bus.if_done_o, bus.mem_done_o}, 0);
    start_cycle();
    rst = 1'b0;

    // IF 4-byte fetch
    run_read(1'b0, 2'b10, 32'h100, 32'h00A00513, 6);
    @(negedge clk);
    check_val("if_done_pulse_width", bus.if_done_o, 0);

    // Simultaneous IF and MEM requests: MEM wins, IF follows after the dead cycle
    got = 1'b0;
    start_cycle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h200;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b00; bus.mem_addr_i = 32'h204;
    if_q.push_back(32'h00100093);
    mem_q.push_back('{1'b1, 32'h000000FF});
    for (int k = 1; k <= 30 && !got; k++) begin
      start_cycle();
      @(negedge clk);
      if (bus.mem_done_o) begin
        check_val("arb_mem_done_cycle", k, 3);
        bus.mem_req_i = 1'b0;
      end
      if (k == 4) check_val("arb_dead_cycle_busy", bus.busy_o, 0);
      if (k == 5) check_val("arb_if_first_addr", bus.ram_a_o, 32'h200);
      if (bus.if_done_o) begin
        got = 1'b1;
        check_val("arb_if_done_cycle", k, 10);
        bus.if_req_i = 1'b0;
      end
    end
    check_val("arb_timeout", got, 1);

    // 2-byte write then readback (upper bytes must read back as zero)
    run_write(2'b01, 32'h30, 32'h0000BEEF, 3);
    run_read(1'b1, 2'b01, 32'h30, 32'h0000BEEF, 4);

    // 4-byte read with rdy low in cycles 3-4
    got = 1'b0;
    start_cycle();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b10; bus.mem_addr_i = 32'h40;
    mem_q.push_back('{1'b1, 32'h44332211});
    for (int k = 1; k <= 30 && !got; k++) begin
      start_cycle();
      rdy = !(k == 3 || k == 4);
      @(negedge clk);
      if (k == 3 || k == 4) check_val("stall_rd_no_done", bus.mem_done_o, 0);
      if (k == 5) check_val("stall_prime_addr", bus.ram_a_o, 32'h41);
      if (bus.mem_done_o) begin
        got = 1'b1;
        check_val("stall_rd_done_cycle", k, 9);
        bus.mem_req_i = 1'b0;
      end
    end
    check_val("stall_rd_timeout", got, 1);

    // 4-byte write with rdy low in cycle 2
    for (int i = 16'h50; i <= 16'h53; i++) wcnt[i] = 0;
    got = 1'b0;
    start_cycle();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b11;
    bus.mem_addr_i = 32'h50; bus.mem_wdata_i = 32'hDDCCBBAA;
    mem_q.push_back('{1'b0, 32'h0});
    for (int k = 1; k <= 30 && !got; k++) begin
      start_cycle();
      rdy = (k != 2);
      @(negedge clk);
      if (k == 2) check_val("stall_wr_gated", bus.ram_wr_o, 0);
      if (k == 3) begin
        check_val("stall_wr_retry_addr", bus.ram_a_o, 32'h51);
        check_val("stall_wr_retry_byte", bus.ram_dout_o, 8'hBB);
        check_val("stall_wr_retry_strobe", bus.ram_wr_o, 1);
      end
      if (bus.mem_done_o) begin
        got = 1'b1;
        check_val("stall_wr_done_cycle", k, 6);
        bus.mem_req_i = 1'b0;
      end
    end
    check_val("stall_wr_timeout", got, 1);
    ones = 0;
    for (int i = 16'h50; i <= 16'h53; i++) if (wcnt[i] == 1) ones++;
    check_val("stall_wr_once", ones, 4);
    check_val("stall_wr_mem", {ram[16'h53], ram[16'h52], ram[16'h51], ram[16'h50]}, 32'hDDCCBBAA);

    // Reset during cycle 3 of an IF fetch aborts it silently
    start_cycle();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
    for (int k = 1; k <= 3; k++) begin
      start_cycle();
      if (k == 3) begin
        rst = 1'b1;
        bus.if_req_i = 1'b0;
      end
    end
    start_cycle();
    rst = 1'b0;
    last_mem_rd = '0;
    @(negedge clk);
    check_val("abort_busy", bus.busy_o, 0);
    check_val("abort_if_data", bus.if_data_o, 0);
    check_val("abort_mem_rdata", bus.mem_rdata_o, 0);
    check_val("abort_ram_a", bus.ram_a_o, 0);
    check_val("abort_ram_wr", bus.ram_wr_o, 0);
    check_val("abort_dones", {bus.if_done_o, bus.mem_done_o}, 0);
    repeat (6) start_cycle();
    run_read(1'b0, 2'b10, 32'h200, 32'h00100093, 6);

    repeat (3) start_cycle();
    check_val("sb_if_empty", if_q.size(), 0);
    check_val("sb_mem_empty", mem_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
